line_sequencer: RTL and testbench

Command-queue controller that sits in front of the vector rasterizer. It buffers line descriptors (endpoints in signed screen-centred coordinates, plus a colour) from the vector-generator front end. It issues them one at a time to the rasterizer using the rasterizer's `readyIn` / `rastReady` / `done` handshake. It reports frame completion once every queued line has been drawn.

---
 rtl/line_sequencer.sv | 168 ++++++++++++++++
 tb/tb_line_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_sequencer.sv
// rtl/line_sequencer.sv - line descriptor queue that launches lines into the rasterizer one at a time
// Optional trivial reject of off-screen lines when LINE_SEQ_REJECT_EN is defined.
module line_sequencer #(
    parameter int DEPTH = 8,
    parameter int CW    = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lineValid,
    input  logic [CW-1:0] inStartX,
    input  logic [CW-1:0] inEndX,
    input  logic [CW-1:0] inStartY,
    input  logic [CW-1:0] inEndY,
    input  logic [3:0]    inColor,
    output logic          lineReady,
    input  logic          frameEnd,
    input  logic          rastReady,
    input  logic          rastDone,
    output logic [CW-1:0] startX,
    output logic [CW-1:0] endX,
    output logic [CW-1:0] startY,
    output logic [CW-1:0] endY,
    output logic [3:0]    lineColor,
    output logic          readyIn,
    output logic          frameDone,
    output logic          busy,
`ifdef LINE_SEQ_REJECT_EN
    output logic [15:0]   linesRejected,
`endif
    output logic [15:0]   linesIssued
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 4 * CW + 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_pend;
    logic [15:0]   r_issued;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_head_out;
    logic          w_frame_done;
    logic [EW-1:0] w_head;

    assign w_full  = (r_count == (AW + 1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = lineValid && !w_full;
    assign w_head  = r_mem[r_rd_ptr];

    assign startX    = w_head[4*CW+3 -: CW];
    assign endX      = w_head[3*CW+3 -: CW];
    assign startY    = w_head[2*CW+3 -: CW];
    assign endY      = w_head[CW+3 -: CW];
    assign lineColor = w_head[3:0];

`ifdef LINE_SEQ_REJECT_EN
    localparam logic signed [CW-1:0] X_MIN = CW'(-320);
    localparam logic signed [CW-1:0] X_MAX = CW'(319);
    localparam logic signed [CW-1:0] Y_MIN = CW'(-240);
    localparam logic signed [CW-1:0] Y_MAX = CW'(239);

    logic signed [CW-1:0] w_sx, w_ex, w_sy, w_ey;
    logic [15:0]          r_rejected;

    assign w_sx = $signed(startX);
    assign w_ex = $signed(endX);
    assign w_sy = $signed(startY);
    assign w_ey = $signed(endY);

    // Both endpoints beyond the same edge means nothing of the line is visible
    assign w_head_out = (w_sx < X_MIN && w_ex < X_MIN) || (w_sx > X_MAX && w_ex > X_MAX) ||
                        (w_sy < Y_MIN && w_ey < Y_MIN) || (w_sy > Y_MAX && w_ey > Y_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rejected <= '0;
        end else if (r_state == ST_IDLE && !w_empty && w_head_out) begin
            r_rejected <= r_rejected + 1'b1;
        end
    end

    assign linesRejected = r_rejected;
`else
    assign w_head_out = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    if (w_head_out) begin
                        w_pop = 1'b1;
                    end else if (rastReady) begin
                        w_state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                w_pop       = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (rastDone) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_frame_done = r_pend && w_empty && (r_state == ST_IDLE) && rastReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_state  <= ST_IDLE;
            r_pend   <= 1'b0;
            r_issued <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {inStartX, inEndX, inStartY, inEndY, inColor};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            r_state <= w_state_nxt;
            if (r_state == ST_ISSUE) begin
                r_issued <= r_issued + 1'b1;
            end
            // A frameEnd arriving while the pulse fires is folded into that same frame
            r_pend <= w_frame_done ? 1'b0 : (r_pend | frameEnd);
        end
    end

    assign lineReady   = !w_full;
    assign readyIn     = (r_state == ST_ISSUE);
    assign frameDone   = w_frame_done;
    assign busy        = !w_empty || (r_state != ST_IDLE);
    assign linesIssued = r_issued;

endmodule

// File: tb/tb_line_sequencer.sv
// tb/tb_line_sequencer.sv - self-checking bench for line_sequencer
module tb_line_sequencer;
    localparam int DEPTH = 8;
    localparam int CW    = 11;
`ifdef LINE_SEQ_REJECT_EN
    localparam bit REJ_EN = 1'b1;
`else
    localparam bit REJ_EN = 1'b0;
`endif

    typedef struct packed {
        logic [CW-1:0] sx;
        logic [CW-1:0] ex;
        logic [CW-1:0] sy;
        logic [CW-1:0] ey;
        logic [3:0]    col;
    } desc_t;

    typedef struct {
        bit    r;
        bit    lv;
        desc_t d;
        bit    fe;
        bit    rr;
        bit    rd;
        bit    chk;
        bit    e_ri;
        bit    e_lr;
        bit    e_busy;
        bit    e_fd;
        int    e_iss;
        int    e_desc;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, lineValid, frameEnd, rastReady, rastDone;
    logic [CW-1:0] inStartX, inEndX, inStartY, inEndY;
    logic [3:0]    inColor;
    logic          lineReady, readyIn, frameDone, busy;
    logic [CW-1:0] startX, endX, startY, endY;
    logic [3:0]    lineColor;
    logic [15:0]   linesIssued;
`ifdef LINE_SEQ_REJECT_EN
    logic [15:0]   linesRejected;
`endif

    line_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .lineValid(lineValid),
        .inStartX(inStartX), .inEndX(inEndX), .inStartY(inStartY), .inEndY(inEndY),
        .inColor(inColor), .lineReady(lineReady), .frameEnd(frameEnd),
        .rastReady(rastReady), .rastDone(rastDone),
        .startX(startX), .endX(endX), .startY(startY), .endY(endY),
        .lineColor(lineColor), .readyIn(readyIn), .frameDone(frameDone), .busy(busy),
`ifdef LINE_SEQ_REJECT_EN
        .linesRejected(linesRejected),
`endif
        .linesIssued(linesIssued)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pending lines, launch strobe expected now, line in flight
    desc_t m_q[$];
    bit    m_launch, m_fly, m_pend, m_valid;
    int    m_issued, m_rej;
    int    cyc, last_done, fd_count;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit lv, input desc_t d, input bit fe, input bit rr, input bit rd);
        rst = r; lineValid = lv; frameEnd = fe; rastReady = rr; rastDone = rd;
        inStartX = d.sx; inEndX = d.ex; inStartY = d.sy; inEndY = d.ey; inColor = d.col;
    endtask

    function automatic bit is_rej(input desc_t d);
        int sx, ex, sy, ey;
        sx = $signed(d.sx); ex = $signed(d.ex); sy = $signed(d.sy); ey = $signed(d.ey);
        return (sx < -320 && ex < -320) || (sx > 319 && ex > 319) ||
               (sy < -240 && ey < -240) || (sy > 239 && ey > 239);
    endfunction

    function automatic vec_t mk(input bit r, input bit lv, input desc_t d, input bit fe, input bit rr,
                                input bit rd, input bit c, input bit ri, input bit lr, input bit b,
                                input bit fd, input int iss, input int ed);
        vec_t v;
        v.r = r; v.lv = lv; v.d = d; v.fe = fe; v.rr = rr; v.rd = rd; v.chk = c;
        v.e_ri = ri; v.e_lr = lr; v.e_busy = b; v.e_fd = fd; v.e_iss = iss; v.e_desc = ed;
        return v;
    endfunction

    function automatic desc_t mkd(input int sx, input int ex, input int sy, input int ey, input int col);
        desc_t d;
        d.sx = CW'(sx); d.ex = CW'(ex); d.sy = CW'(sy); d.ey = CW'(ey); d.col = 4'(col);
        return d;
    endfunction

    task automatic cycle(input bit r, input bit lv, input desc_t d, input bit fe, input bit rr, input bit rd);
        bit exp_fd;
        int sz;
        @(negedge clk);
        drive(r, lv, d, fe, rr, rd);
        #1;
        exp_fd = m_pend && (m_q.size() == 0) && !m_launch && !m_fly && rr;
        if (m_valid) begin
            chk("readyIn", readyIn, m_launch);
            chk("lineReady", lineReady, m_q.size() < DEPTH);
            chk("busy", busy, (m_q.size() > 0) || m_launch || m_fly);
            chk("frameDone", frameDone, exp_fd);
            chk("linesIssued", linesIssued, 16'(m_issued));
`ifdef LINE_SEQ_REJECT_EN
            chk("linesRejected", linesRejected, 16'(m_rej));
`endif
            if (m_launch) begin
                chk("desc", {startX, endX, startY, endY, lineColor}, m_q[0]);
                if (last_done >= 0) chk("gap", (cyc - last_done) >= 2, 1);
            end
            if (frameDone) fd_count++;
        end
        @(posedge clk);
        cyc++;
        if (r) begin
            m_q.delete();
            m_launch = 0; m_fly = 0; m_pend = 0; m_issued = 0; m_rej = 0;
            m_valid = 1; last_done = -1;
        end else begin
            sz = m_q.size();
            if (m_launch) begin
                void'(m_q.pop_front());
                m_issued++;
                m_launch = 0;
                m_fly = 1;
            end else if (m_fly) begin
                if (rd) begin
                    m_fly = 0;
                    last_done = cyc - 1;
                end
            end else if (sz > 0) begin
                if (REJ_EN && is_rej(m_q[0])) begin
                    void'(m_q.pop_front());
                    m_rej++;
                end else if (rr) begin
                    m_launch = 1;
                end
            end
            if (lv && sz < DEPTH) m_q.push_back(d);
            m_pend = exp_fd ? 1'b0 : (m_pend | fe);
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((m_q.size() > 0 || m_launch || m_fly) && n < budget) begin
            cycle(0, 0, '0, 0, 1, m_fly);
            n++;
        end
        chk("drain_timeout", n < budget, 1);
    endtask

    vec_t  tbl[$];
    desc_t L1, Z;

    initial begin
        Z = '0;
        L1 = mkd(-25, 75, 50, 250, 4'hA);
        drive(1, 0, Z, 0, 1, 0);
        m_valid = 0; cyc = 0; last_done = -1; fd_count = 0;

        tbl.push_back(mk(1, 0, Z,  0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, Z,  0, 1, 0, 1, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk(0, 1, L1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, Z,  0, 1, 0, 1, 0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, Z,  0, 1, 0, 1, 1, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, Z,  0, 1, 0, 1, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, Z,  0, 0, 0, 1, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, Z,  0, 0, 1, 1, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, Z,  0, 1, 0, 1, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, Z,  1, 1, 0, 1, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, Z,  0, 1, 0, 1, 0, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, Z,  0, 1, 0, 1, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, Z,  0, 1, 1, 1, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, Z,  0, 1, 0, 1, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, Z,  1, 0, 0, 1, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, Z,  0, 0, 0, 1, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, Z,  0, 1, 0, 1, 0, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, Z,  0, 1, 0, 1, 0, 1, 0, 0, 1, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].r, tbl[i].lv, tbl[i].d, tbl[i].fe, tbl[i].rr, tbl[i].rd);
            #1;
            if (tbl[i].chk) begin
                chk($sformatf("t%0d_readyIn", i), readyIn, tbl[i].e_ri);
                chk($sformatf("t%0d_lineReady", i), lineReady, tbl[i].e_lr);
                chk($sformatf("t%0d_busy", i), busy, tbl[i].e_busy);
                chk($sformatf("t%0d_frameDone", i), frameDone, tbl[i].e_fd);
                chk($sformatf("t%0d_linesIssued", i), linesIssued, 16'(tbl[i].e_iss));
                if (tbl[i].e_desc == 1)
                    chk($sformatf("t%0d_desc", i), {startX, endX, startY, endY, lineColor}, L1);
                if (tbl[i].e_desc == 2)
                    chk($sformatf("t%0d_desc0", i), {startX, endX, startY, endY, lineColor}, '0);
            end
            @(posedge clk);
        end

        // Fill while the rasterizer is busy, try a 9th push, then release
        cycle(1, 0, Z, 0, 0, 0);
        for (int i = 0; i < 9; i++) cycle(0, 1, mkd(i * 3, i * 5 + 1, -i, i + 100, i), 0, 0, 0);
        drain(200);
        chk("fill_issued", linesIssued, 8);

        // frameEnd with the last of three pushes, plus a redundant frameEnd while pending
        cycle(1, 0, Z, 0, 1, 0);
        fd_count = 0;
        cycle(0, 1, mkd(20, 21, 22, 23, 1), 0, 1, 0);
        cycle(0, 1, mkd(30, 31, 32, 33, 2), 0, 1, m_fly);
        cycle(0, 1, mkd(40, 41, 42, 43, 3), 1, 1, m_fly);
        cycle(0, 0, Z, 1, 1, m_fly);
        drain(100);
        for (int i = 0; i < 3; i++) cycle(0, 0, Z, 0, 1, 0);
        chk("frame_pulses", fd_count, 1);

        // Reset while a line is in flight with four more queued
        cycle(1, 0, Z, 0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, mkd(i + 50, i, i, i, i), 0, 1, 0);
        chk("pre_rst_fly", m_fly && m_q.size() == 4, 1);
        cycle(1, 0, Z, 0, 1, 0);
        @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_lineReady", lineReady, 1);
        chk("rst_linesIssued", linesIssued, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, Z, 0, 1, 0);

`ifdef LINE_SEQ_REJECT_EN
        cycle(1, 0, Z, 0, 1, 0);
        cycle(0, 1, mkd(-400, -350, 0, 100, 5), 0, 1, 0);
        cycle(0, 1, mkd(0, 10, 0, 10, 6), 0, 1, 0);
        drain(50);
        chk("rej_count", linesRejected, 1);
        chk("rej_issued", linesIssued, 1);
`endif

        // Randomised traffic against the model
        cycle(1, 0, Z, 0, 1, 0);
        for (int i = 0; i < 3000; i++) begin
            desc_t d;
            bit rd;
            d = mkd(int'($urandom_range(0, 1000)) - 500, int'($urandom_range(0, 1000)) - 500,
                    int'($urandom_range(0, 800)) - 400, int'($urandom_range(0, 800)) - 400,
                    int'($urandom_range(0, 15)));
            rd = m_fly ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 29) == 0);
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 1), d,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, rd);
        end
        drain(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
